// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler
// Round-robin arbiter that shares one uart_top transmitter between N_REQ
// byte producers. It accepts one byte per grant, drives sel_baud with that
// requester's baud selection, strobes tx_en for EN_HOLD cycles and then
// follows tx_status until the frame ends or the start timeout expires.
//
// Ports
//   sys_clk, rst      clock, synchronous active-high reset
//   req_valid/ready   per-requester handshake (ready is one-hot, IDLE only)
//   req_data/baud     packed per-requester byte and baud select
//   tx_status         transmitter busy flag from uart_top
//   tx_en/tx_d_in     frame start strobe and byte to uart_top
//   sel_baud          baud select to uart_top
//   grant_id          requester owning the current frame
//   busy              high whenever the FSM is not in IDLE
//   done/timeout_err  one-cycle completion / no-start pulses
//
// state     | meaning
// ----------+---------------------------------------------------
// IDLE      | arbitrating, req_ready offered to the winner
// LAUNCH    | tx_en held high for EN_HOLD cycles
// WAIT_BUSY | waiting for tx_status to rise, START_TO cycle limit
// WAIT_DONE | frame in flight, waiting for tx_status to fall
module uart_tx_scheduler #(
  parameter int N_REQ    = 4,
  parameter int EN_HOLD  = 10,
  parameter int START_TO = 64
) (
  input  logic                       sys_clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [8*N_REQ-1:0]         req_data,
  input  logic [2*N_REQ-1:0]         req_baud,
  output logic [N_REQ-1:0]           req_ready,
  input  logic                       tx_status,
  output logic                       tx_en,
  output logic [7:0]                 tx_d_in,
  output logic [1:0]                 sel_baud,
  output logic [$clog2(N_REQ)-1:0]   grant_id,
  output logic                       busy,
  output logic                       done,
  output logic                       timeout_err
);

  localparam int PW = $clog2(N_REQ);
  localparam int EW = $clog2(EN_HOLD + 1);
  localparam int TW = $clog2(START_TO + 1);
  localparam logic [N_REQ-1:0] ONE_HOT0 = {{(N_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t        state;
  logic [PW-1:0] ptr;
  logic [EW-1:0] en_cnt;
  logic [TW-1:0] to_cnt;
  logic [PW-1:0] winner;
  logic          any_valid;

  // Search upward from ptr with wrap; the first valid requester wins.
  always_comb begin
    winner    = '0;
    any_valid = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!any_valid && req_valid[(int'(ptr) + k) % N_REQ]) begin
        any_valid = 1'b1;
        winner    = PW'((int'(ptr) + k) % N_REQ);
      end
    end
  end

  assign req_ready = (state == IDLE && any_valid) ? (ONE_HOT0 << winner) : '0;
  assign busy      = (state != IDLE);

  // done/timeout_err must be high in the very cycle the FSM leaves its wait
  // state, so they are decoded from registered state plus tx_status rather
  // than registered themselves. rst masks them so an abandoned frame never
  // reports completion.
  assign done        = !rst && (state == WAIT_DONE) && !tx_status;
  assign timeout_err = !rst && (state == WAIT_BUSY) && !tx_status && (to_cnt == '0);

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= '0;
      en_cnt   <= '0;
      to_cnt   <= '0;
      tx_en    <= 1'b0;
      tx_d_in  <= 8'h00;
      sel_baud <= 2'b01;
      grant_id <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_valid) begin
            tx_d_in  <= req_data[{winner, 3'b000} +: 8];
            sel_baud <= req_baud[{winner, 1'b0} +: 2];
            grant_id <= winner;
            ptr      <= (winner == PW'(N_REQ - 1)) ? '0 : winner + PW'(1);
            tx_en    <= 1'b1;
            en_cnt   <= EW'(EN_HOLD - 1);
            state    <= LAUNCH;
          end
        end
        LAUNCH: begin
          if (en_cnt == '0) begin
            tx_en  <= 1'b0;
            to_cnt <= TW'(START_TO - 1);
            state  <= WAIT_BUSY;
          end else begin
            en_cnt <= en_cnt - EW'(1);
          end
        end
        WAIT_BUSY: begin
          // to_cnt reaches 0 on WAIT_BUSY cycle START_TO.
          if (tx_status) begin
            state <= WAIT_DONE;
          end else if (to_cnt == '0) begin
            state <= IDLE;
          end else begin
            to_cnt <= to_cnt - TW'(1);
          end
        end
        WAIT_DONE: begin
          if (!tx_status) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler. tx_status is driven by the bench in
// place of uart_top. Expected grants are queued when a request is offered
// and popped when tx_en starts the frame.
module tb_uart_tx_scheduler;

  logic        sys_clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [7:0]  req_baud;
  logic [3:0]  req_ready;
  logic        tx_status;
  logic        tx_en;
  logic [7:0]  tx_d_in;
  logic [1:0]  sel_baud;
  logic [1:0]  grant_id;
  logic        busy;
  logic        done;
  logic        timeout_err;

  typedef struct packed {
    logic [1:0] g;
    logic [7:0] d;
    logic [1:0] b;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   n_assert = 0;
  int   n_fail   = 0;

  uart_tx_scheduler #(.N_REQ(4), .EN_HOLD(10), .START_TO(64)) dut (
    .sys_clk     (sys_clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_baud    (req_baud),
    .req_ready   (req_ready),
    .tx_status   (tx_status),
    .tx_en       (tx_en),
    .tx_d_in     (tx_d_in),
    .sel_baud    (sel_baud),
    .grant_id    (grant_id),
    .busy        (busy),
    .done        (done),
    .timeout_err (timeout_err)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic step(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [7:0] d, input logic [1:0] b);
    req_data[8*i +: 8] = d;
    req_baud[2*i +: 2] = b;
  endtask

  // Called at a negedge with req_valid already driven; acceptance happens on
  // the following posedge.
  task automatic accept(input logic [1:0] g, input logic [7:0] d, input logic [1:0] b);
    exp_t e;
    logic [3:0] oh;
    #1;
    oh = 4'b0001 << g;
    chk("req_ready_offer", req_ready, oh);
    e.g = g; e.d = d; e.b = b;
    sb.push_back(e);
    step(1);
  endtask

  // Entered at the first negedge after acceptance; returns at the first
  // WAIT_BUSY cycle.
  task automatic check_launch();
    int cnt;
    chk("busy_after_accept", busy, 1'b1);
    chk("tx_en_start", tx_en, 1'b1);
    if (sb.size() == 0) begin
      chk("scoreboard_nonempty", 32'(sb.size()), 32'd1);
      cur = '0;
    end else begin
      cur = sb.pop_front();
    end
    chk("tx_d_in", tx_d_in, cur.d);
    chk("sel_baud", sel_baud, cur.b);
    chk("grant_id", grant_id, cur.g);
    cnt = 0;
    while (tx_en === 1'b1 && cnt < 40) begin
      cnt++;
      step(1);
    end
    chk("tx_en_length", cnt, 10);
  endtask

  // Raises tx_status on WAIT_BUSY cycle 3, holds it for 'hold' cycles,
  // optionally raising late requests, then drops it and checks done.
  task automatic finish_frame(input int hold, input logic [3:0] late_mask);
    logic stable;
    step(2);
    chk("no_early_timeout", timeout_err, 1'b0);
    tx_status = 1'b1;
    stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      step(1);
      if (i == 0) req_valid = req_valid | late_mask;
      #1;
      if (sel_baud !== cur.b || done !== 1'b0 || req_ready !== 4'b0 ||
          tx_en !== 1'b0 || busy !== 1'b1) stable = 1'b0;
    end
    chk("in_flight_stable", stable, 1'b1);
    step(1);
    tx_status = 1'b0;
    #1;
    chk("done_pulse", done, 1'b1);
    chk("no_timeout_on_done", timeout_err, 1'b0);
    step(1);
    chk("done_one_cycle", done, 1'b0);
    chk("idle_after_done", busy, 1'b0);
  endtask

  initial begin
    int   k;
    logic saw_done;

    rst       = 1'b1;
    req_valid = '0;
    req_data  = '0;
    req_baud  = '0;
    tx_status = 1'b0;
    step(3);

    // Reset state
    chk("rst_tx_en", tx_en, 1'b0);
    chk("rst_tx_d_in", tx_d_in, 8'h00);
    chk("rst_sel_baud", sel_baud, 2'b01);
    chk("rst_grant_id", grant_id, 2'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_timeout", timeout_err, 1'b0);
    chk("rst_req_ready", req_ready, 4'b0);
    rst = 1'b0;

    // Single byte
    set_req(0, 8'hA5, 2'b01);
    req_valid = 4'b0001;
    accept(2'd0, 8'hA5, 2'b01);
    req_valid = '0;
    check_launch();
    finish_frame(5, 4'b0);

    // Round-robin from a fresh pointer, all requesters held valid
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    set_req(0, 8'h10, 2'b01);
    set_req(1, 8'h21, 2'b01);
    set_req(2, 8'h32, 2'b01);
    set_req(3, 8'h43, 2'b01);
    req_valid = 4'b1111;
    accept(2'd0, 8'h10, 2'b01); check_launch(); finish_frame(3, 4'b0);
    accept(2'd1, 8'h21, 2'b01); check_launch(); finish_frame(3, 4'b0);
    accept(2'd2, 8'h32, 2'b01); check_launch(); finish_frame(3, 4'b0);
    accept(2'd3, 8'h43, 2'b01); check_launch(); finish_frame(3, 4'b0);
    accept(2'd0, 8'h10, 2'b01); check_launch(); finish_frame(3, 4'b0);
    req_valid = '0;

    // Baud switching (pointer now at 1)
    set_req(1, 8'h3C, 2'b00);
    set_req(2, 8'hC3, 2'b10);
    req_valid = 4'b0110;
    accept(2'd1, 8'h3C, 2'b00);
    req_valid = 4'b0100;
    check_launch();
    finish_frame(8, 4'b0);
    accept(2'd2, 8'hC3, 2'b10);
    req_valid = '0;
    check_launch();
    finish_frame(8, 4'b0);

    // Timeout: tx_status never rises (pointer now at 3)
    set_req(3, 8'h5A, 2'b11);
    req_valid = 4'b1000;
    accept(2'd3, 8'h5A, 2'b11);
    req_valid = '0;
    check_launch();
    k = 11;
    saw_done = 1'b0;
    while (timeout_err !== 1'b1 && k < 200) begin
      step(1);
      k++;
      if (done === 1'b1) saw_done = 1'b1;
    end
    chk("timeout_cycle", k, 74);
    chk("no_done_on_timeout", saw_done, 1'b0);
    chk("timeout_busy", busy, 1'b1);
    step(1);
    chk("timeout_one_cycle", timeout_err, 1'b0);
    chk("idle_after_timeout", busy, 1'b0);
    set_req(0, 8'h77, 2'b01);
    req_valid = 4'b0001;
    accept(2'd0, 8'h77, 2'b01);
    req_valid = '0;
    check_launch();
    finish_frame(4, 4'b0);

    // Reset three cycles into WAIT_DONE (pointer now at 1)
    set_req(1, 8'h99, 2'b10);
    req_valid = 4'b0010;
    accept(2'd1, 8'h99, 2'b10);
    req_valid = '0;
    check_launch();
    step(2);
    tx_status = 1'b1;
    step(3);
    chk("pre_rst_busy", busy, 1'b1);
    rst = 1'b1;
    step(1);
    chk("mid_rst_tx_en", tx_en, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_sel_baud", sel_baud, 2'b01);
    chk("mid_rst_grant_id", grant_id, 2'd0);
    chk("mid_rst_tx_d_in", tx_d_in, 8'h00);
    tx_status = 1'b0;
    rst = 1'b0;
    #1;
    chk("mid_rst_no_done", done, 1'b0);
    set_req(2, 8'h2C, 2'b00);
    req_valid = 4'b0100;
    accept(2'd2, 8'h2C, 2'b00);
    req_valid = '0;
    check_launch();
    finish_frame(4, 4'b0);

    // Late request from req3 during a req0 frame (pointer now at 3)
    set_req(0, 8'hE1, 2'b01);
    set_req(3, 8'hD4, 2'b11);
    req_valid = 4'b0001;
    accept(2'd0, 8'hE1, 2'b01);
    req_valid = '0;
    check_launch();
    finish_frame(6, 4'b1000);
    accept(2'd3, 8'hD4, 2'b11);
    req_valid = '0;
    check_launch();
    finish_frame(3, 4'b0);

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_scheduler.md
# uart_tx_scheduler

Round-robin scheduler that shares the single `uart_top` transmitter between `N_REQ` byte producers. It accepts one byte per grant through a valid/ready handshake and programs `sel_baud` with that requester's baud selection. It then strobes `tx_en`/`tx_d_in` into `uart_top` and tracks `tx_status` until the frame completes. It sits between the producer blocks and `uart_top` and is the only driver of `uart_top`'s TX-side inputs.

## Interface
- `N_REQ`, 4: number of requesters, 2..8.
- `EN_HOLD`, 10: cycles `tx_en` is held high per frame, at least 1.
- `START_TO`, 64: maximum cycles from the end of `tx_en` to the `tx_status` rise.
- `sys_clk`  in  1  system clock; every register in this block uses its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  N_REQ  per-requester byte available.
- `req_data`  in  8*N_REQ  byte of requester i in bits [8i+7:8i].
- `req_baud`  in  2*N_REQ  baud select of requester i in bits [2i+1:2i], same encoding as `sel_baud`.
- `req_ready`  out  N_REQ  one-hot accept; a transfer happens on a cycle where `req_valid[i]` and `req_ready[i]` are both high.
- `tx_status`  in  1  from `uart_top`; 1 while the transmitter is busy with a frame.
- `tx_en`  out  1  to `uart_top`; frame start strobe.
- `tx_d_in`  out  8  to `uart_top`; byte to send.
- `sel_baud`  out  2  to `uart_top`; baud select.
- `grant_id`  out  $clog2(N_REQ)  index of the requester owning the current frame.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse when a frame completes normally.
- `timeout_err`  out  1  one-cycle pulse when `tx_status` never rose.

## Operation
- States: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE.
- **Arbitration:** round-robin pointer `ptr`. The winner is the first i with `req_valid[i]`=1, searching from `ptr` upward with wrap to 0.
- **`req_ready`:** combinational. It equals the one-hot winner when state=IDLE and is 0 in every other state.
- **IDLE:** if any valid, then on the accepting edge:
  - latch `req_data[winner]` into `tx_d_in` and `req_baud[winner]` into `sel_baud`;
  - set `grant_id`=winner and `ptr`=(winner+1) mod N_REQ;
  - go to LAUNCH.
- **LAUNCH:** `tx_en`=1 for exactly `EN_HOLD` cycles (counter), then go to WAIT_BUSY.
- **WAIT_BUSY:**
  - If `tx_status`=1, go to WAIT_DONE.
  - Otherwise count. After `START_TO` cycles with no rise, pulse `timeout_err` and go to IDLE.
  - A `tx_status` that is already 1 on the first cycle counts as a rise.
- **WAIT_DONE:** on `tx_status`=0, pulse `done` and go to IDLE. There is no timeout; the frame length depends on baud.
- `tx_d_in`, `sel_baud` and `grant_id` hold their values from acceptance until the next acceptance. `sel_baud` therefore never changes while a frame is in flight.
- A requester that drops `req_valid` before it is granted loses nothing: no state is kept per requester.
- `req_valid` changes outside IDLE are ignored.

## Timing
- **Reset values:**
  - `tx_en`=0, `tx_d_in`=8'h00, `sel_baud`=2'b01, `grant_id`=0;
  - `busy`=0, `done`=0, `timeout_err`=0;
  - `ptr`=0, state=IDLE, all counters 0.
- **Reset priority:** reset in any state forces the reset values on the next edge. An in-flight frame is abandoned: `tx_en` drops immediately, and no `done` or `timeout_err` is issued.
- **Accept to `tx_en`:** acceptance at edge T gives `tx_en`=1 during cycles T+1 .. T+EN_HOLD and `busy`=1 from T+1.
- **Back-to-back:** after `done` or `timeout_err` the block is in IDLE in the following cycle and can accept that same cycle. The minimum gap from the end of one frame to the next acceptance is 1 cycle.
- **`done` / `timeout_err`:** each is high for exactly the one cycle in which the state leaves WAIT_DONE or WAIT_BUSY respectively. Both are never high together.
- **Timeout window:** counted from the first WAIT_BUSY cycle. `timeout_err` asserts on WAIT_BUSY cycle `START_TO` (counting the first WAIT_BUSY cycle as 1).
- **Simultaneous requests:** all `req_valid` high gives grants in order ptr, ptr+1, … with wrap. No requester waits more than N_REQ-1 frames.

## Test plan
- **Single byte:** after reset, `req_valid[0]`=1, `req_data[0]`=8'hA5, `req_baud[0]`=2'b01.
  - Expect: `req_ready[0]` high one cycle; `tx_en` high 10 cycles; `tx_d_in`=8'hA5; `sel_baud`=01.
  - `uart_top` loopback: `rx_d_out`=8'hA5; `done` pulses once when `tx_status` falls.
- **Round-robin:** all four valid with bytes 8'h10, 8'h21, 8'h32, 8'h43 held high.
  - Expect: grants 0,1,2,3,0; `tx_d_in` sequence 10,21,32,43,10; `ptr` wraps.
- **Baud switching:** req1 baud 2'b00 with 8'h3C, req2 baud 2'b10 with 8'hC3.
  - Expect: `sel_baud` 00 for the first frame and 10 for the second, stable through each `tx_status` high window.
  - Loopback receives 3C then C3.
- **Timeout:** `tx_status` forced 0 by a stub.
  - Expect: `timeout_err` pulses exactly 10+64 cycles after acceptance; no `done`; state returns to IDLE; the next request is accepted.
- **Reset mid-frame:** assert `rst` 3 cycles into WAIT_DONE.
  - Expect: next edge has `tx_en`=0, `busy`=0, `sel_baud`=01, `grant_id`=0; no `done`.
  - After release, a `req_valid[2]` request is granted with `ptr` restarted at 0.
- **Late request:** `req_valid[3]` rises during WAIT_DONE of a req0 frame.
  - Expect: `req_ready` stays 0 until IDLE; req3 is granted in the cycle after `done`.
